// File: rtl/obi_mem_sub.sv
// obi_mem_sub: OBI subordinate backed by a word-addressed memory, with a fixed-latency
// response pipeline, an in-order response FIFO and rready back-pressure.
module obi_mem_sub #(
    parameter int                      AddressWidth   = 32,
    parameter int                      DataWidth      = 32,
    parameter int                      IdWidth        = 1,
    parameter int                      NumWords       = 1024,
    parameter logic [AddressWidth-1:0] BaseAddr       = '0,
    parameter int                      Latency        = 1,
    parameter int                      MaxOutstanding = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     obi_req_i,
    output logic                     obi_gnt_o,
    input  logic [AddressWidth-1:0]  obi_addr_i,
    input  logic                     obi_we_i,
    input  logic [DataWidth/8-1:0]   obi_be_i,
    input  logic [DataWidth-1:0]     obi_wdata_i,
    input  logic [IdWidth-1:0]       obi_aid_i,
    output logic                     obi_rvalid_o,
    input  logic                     obi_rready_i,
    output logic [DataWidth-1:0]     obi_rdata_o,
    output logic                     obi_err_o,
    output logic [IdWidth-1:0]       obi_rid_o
);
    localparam int Bw = DataWidth / 8;
    localparam int Ob = $clog2(Bw);
    localparam int Iw = $clog2(NumWords);
    localparam int Pw = $clog2(MaxOutstanding);
    localparam int Cw = $clog2(MaxOutstanding + 1);

    typedef struct packed {
        logic [DataWidth-1:0] d;
        logic                 e;
        logic [IdWidth-1:0]   id;
    } pay_t;

    logic [DataWidth-1:0]    r_mem [NumWords];
    pay_t                    r_fifo [MaxOutstanding];
    logic [Pw:0]             r_wp, r_rp;
    logic [Cw-1:0]           r_cnt;
    logic [AddressWidth-1:0] w_off, w_idx;
    logic                    w_in_rng, w_gnt, w_pop, w_empty, w_full, w_push_v;
    pay_t                    w_in, w_push, w_head;

    assign w_off    = obi_addr_i - BaseAddr;
    assign w_idx    = w_off >> Ob;
    assign w_in_rng = (obi_addr_i >= BaseAddr) && (w_idx < AddressWidth'(NumWords));
    assign w_gnt    = obi_req_i && (r_cnt < Cw'(MaxOutstanding)) && !rst_i;
    // Read data is taken at the grant edge, so a write one cycle earlier is already visible.
    assign w_in     = '{d: (w_in_rng && !obi_we_i) ? r_mem[w_idx[Iw-1:0]] : '0,
                        e: !w_in_rng, id: obi_aid_i};

    always_ff @(posedge clk_i) begin
        if (w_gnt && obi_we_i && w_in_rng) begin
            for (int b = 0; b < Bw; b++) begin
                if (obi_be_i[b]) r_mem[w_idx[Iw-1:0]][8*b +: 8] <= obi_wdata_i[8*b +: 8];
            end
        end
    end

    // The FIFO write itself is the last latency stage, so only Latency-1 registers precede it.
    generate
        if (Latency == 1) begin : g_lat1
            assign w_push_v = w_gnt;
            assign w_push   = w_in;
        end else begin : g_latn
            logic [Latency-2:0] r_pv;
            pay_t               r_pd [Latency-1];
            always_ff @(posedge clk_i) begin
                r_pv[0] <= w_gnt;
                r_pd[0] <= w_in;
                for (int k = 1; k < Latency - 1; k++) begin
                    r_pv[k] <= r_pv[k-1] && !rst_i;
                    r_pd[k] <= r_pd[k-1];
                end
            end
            assign w_push_v = r_pv[Latency-2];
            assign w_push   = r_pd[Latency-2];
        end
    endgenerate

    assign w_empty      = r_wp == r_rp;
    assign w_full       = (r_wp ^ r_rp) == {1'b1, {Pw{1'b0}}};
    assign w_head       = r_fifo[r_rp[Pw-1:0]];
    assign obi_gnt_o    = w_gnt;
    assign obi_rvalid_o = !w_empty && !rst_i;
    assign w_pop        = obi_rvalid_o && obi_rready_i;
    assign obi_rdata_o  = obi_rvalid_o ? w_head.d : '0;
    assign obi_err_o    = obi_rvalid_o && w_head.e;
    assign obi_rid_o    = obi_rvalid_o ? w_head.id : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_v) begin
                r_fifo[r_wp[Pw-1:0]] <= w_push;
                r_wp                 <= r_wp + 1'b1;
            end
            r_rp  <= r_rp + {{Pw{1'b0}}, w_pop};
            r_cnt <= r_cnt + Cw'(w_gnt) - Cw'(w_pop);
        end
    end

    a_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !(w_push_v && w_full && !w_pop));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(w_pop && w_empty));
    a_cnt_bound:    assert property (@(posedge clk_i) r_cnt <= Cw'(MaxOutstanding));
    a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        obi_rvalid_o && !obi_rready_i |=> $stable({obi_rvalid_o, obi_rdata_o, obi_err_o, obi_rid_o}));
endmodule

// File: tb/tb_obi_mem_sub.sv
// tb_obi_mem_sub: directed vector table plus hand-written back-pressure, streaming and reset sequences.
module tb_obi_mem_sub;
    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, rready = 1'b1;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [3:0]  be = 4'hF;
    logic        aid = 1'b0, gnt, rvalid, err, rid;
    int          checks = 0, failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        id;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t        v [15];
    logic [32:0] q [$];
    logic [32:0] bp_exp [5];
    logic [31:0] bp_addr [4];

    obi_mem_sub #(
        .AddressWidth(32), .DataWidth(32), .IdWidth(1), .NumWords(64),
        .BaseAddr(32'h1000), .Latency(3), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr),
        .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_aid_i(aid),
        .obi_rvalid_o(rvalid), .obi_rready_i(rready), .obi_rdata_o(rdata),
        .obi_err_o(err), .obi_rid_o(rid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic xact(input vec_t x, output logic [31:0] rd, output logic e, output logic id, output int lat);
        int n = 0;
        req = 1'b1; we = x.we; addr = x.addr; be = x.be; wdata = x.wd; aid = x.id;
        #1;
        while (!gnt && n < 10) begin @(posedge clk); #2; n++; end
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!rvalid && lat < 10) begin @(posedge clk); #1; lat++; end
        rd = rdata; e = err; id = rid;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e, id;
        int          lat;
        vec_t        x;
        v[0]  = '{1'b1, 32'h1000, 4'hF, 32'h55555555, 1'b0, 32'h0,        1'b0};
        v[1]  = '{1'b1, 32'h1008, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
        v[2]  = '{1'b0, 32'h1008, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        v[3]  = '{1'b1, 32'h1004, 4'hF, 32'h11223344, 1'b1, 32'h0,        1'b0};
        v[4]  = '{1'b1, 32'h1004, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0,        1'b0};
        v[5]  = '{1'b0, 32'h1004, 4'h0, 32'h0,        1'b1, 32'h11BB33DD, 1'b0};
        v[6]  = '{1'b0, 32'h1100, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1};
        v[7]  = '{1'b1, 32'h1100, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        v[8]  = '{1'b0, 32'h1000, 4'hF, 32'h0,        1'b0, 32'h55555555, 1'b0};
        v[9]  = '{1'b1, 32'h10FC, 4'hF, 32'h0BADF00D, 1'b1, 32'h0,        1'b0};
        v[10] = '{1'b0, 32'h10FC, 4'hF, 32'h0,        1'b0, 32'h0BADF00D, 1'b0};
        v[11] = '{1'b0, 32'h0FFC, 4'hF, 32'h0,        1'b1, 32'h0,        1'b1};
        v[12] = '{1'b0, 32'h100A, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        v[13] = '{1'b1, 32'h1008, 4'h0, 32'h12345678, 1'b1, 32'h0,        1'b0};
        v[14] = '{1'b0, 32'h1008, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        bp_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h10FC};
        bp_exp  = '{{1'b0, 32'h55555555}, {1'b1, 32'h11BB33DD}, {1'b0, 32'hDEADBEEF},
                    {1'b1, 32'h0BADF00D}, {1'b1, 32'hDEADBEEF}};

        req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        rst = 1'b0; req = 1'b0;
        #1;
        chk("idle_rvalid", rvalid, 0);
        chk("idle_rdata", rdata, 0);

        for (int i = 0; i < 15; i++) begin
            xact(v[i], rd, e, id, lat);
            chk($sformatf("vec%0d_rdata", i), rd, v[i].ed);
            chk($sformatf("vec%0d_err", i), e, v[i].ee);
            chk($sformatf("vec%0d_rid", i), id, v[i].id);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 3);
        end
        @(posedge clk); #1;

        // Back-pressure: four outstanding reads fill the window, the fifth waits for a retire.
        rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req = 1'b1; we = 1'b0; be = 4'hF; addr = bp_addr[k]; aid = k[0];
            #1 chk("bp_gnt", gnt, 1);
            @(posedge clk); #1;
        end
        addr = 32'h1008; aid = 1'b1;
        #1 chk("bp_gnt_full", gnt, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            chk("bp_hold_gnt", gnt, 0);
            chk("bp_hold_rvalid", rvalid, 1);
            chk("bp_hold_rid", rid, 0);
            chk("bp_hold_rdata", rdata, 32'h55555555);
        end
        q.delete();
        q.push_back({rid, rdata});
        rready = 1'b1;
        #1 chk("bp_no_comb_gnt", gnt, 0);
        @(posedge clk); #1;
        chk("bp_gnt_after_retire", gnt, 1);
        for (int n = 0; n < 12; n++) begin
            if (rvalid) q.push_back({rid, rdata});
            @(posedge clk); #1;
            req = 1'b0;
        end
        chk("bp_resp_count", q.size(), 5);
        for (int i = 0; i < 5 && i < q.size(); i++) chk($sformatf("bp_resp%0d", i), 32'(q[i] != bp_exp[i]), 0);

        // Streaming: preload 16 words, then read them back-to-back.
        for (int i = 0; i < 16; i++) begin
            x = '{1'b1, 32'h1040 + 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i), 1'b0, 32'h0, 1'b0};
            xact(x, rd, e, id, lat);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 24; c++) begin
            req = (c < 16); we = 1'b0; addr = 32'h1040 + 32'(4 * c);
            #1;
            if (c < 16) chk("stream_gnt", gnt, 1);
            chk($sformatf("stream_rvalid_c%0d", c), rvalid, 32'(c >= 3 && c < 19));
            if (rvalid) chk($sformatf("stream_rdata_c%0d", c), rdata, 32'hC0DE0000 + 32'(c - 3));
            @(posedge clk); #1;
        end

        // Reset with three reads in flight: all of them must vanish.
        rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = 1'b1; addr = 32'h1008;
            #1; @(posedge clk); #1;
        end
        req = 1'b0;
        @(posedge clk); #1;
        chk("prerst_rvalid", rvalid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("postrst_rvalid", rvalid, 0);
        for (int k = 0; k < 4; k++) begin
            req = 1'b1; addr = 32'h1040 + 32'(4 * k);
            #1 chk("postrst_gnt", gnt, 1);
            @(posedge clk); #2;
        end
        req = 1'b0; rready = 1'b1;
        q.delete();
        for (int n = 0; n < 10; n++) begin
            if (rvalid) q.push_back({1'b0, rdata});
            @(posedge clk); #1;
        end
        chk("postrst_resp_count", q.size(), 4);
        for (int i = 0; i < 4 && i < q.size(); i++) chk($sformatf("postrst_resp%0d", i), q[i][31:0], 32'hC0DE0000 + 32'(i));
        x = '{1'b0, 32'h1008, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        xact(x, rd, e, id, lat);
        chk("postrst_mem_rdata", rd, 32'hDEADBEEF);
        chk("postrst_mem_rid", id, 1);
        x = '{1'b0, 32'h107C, 4'hF, 32'h0, 1'b0, 32'hC0DE000F, 1'b0};
        xact(x, rd, e, id, lat);
        chk("postrst_mem_last", rd, 32'hC0DE000F);
        chk("postrst_mem_latency", 32'(lat), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
